// File: rtl/arb_mux_n_pkg.sv
// Shared definitions for the parametrised channel arbiter/mux: default
// sizes, the arbitration mode encoding and a constant-evaluable log2 helper.
package arb_mux_n_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_CHANNELS = 8;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Smallest n with 2**n >= value; callers guarantee value >= 2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_mux_n_rr_pick.sv
// Wrap-around priority scan: starting just after ptr, return the first
// requesting channel. Purely combinational.
module rr_pick_n #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the farthest position inward so the nearest request after ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-way stream mux with a single registered output stage. The source channel
// is either chosen by sel (fixed mode) or round-robin among valid channels.
module arb_mux_n
    import arb_mux_n_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS,
    localparam int SEL_W   = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rr_en,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    mode_e            mode;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_found;
    logic             fixed_grant;
    logic [SEL_W-1:0] candidate;
    logic             grant;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    assign mode = mode_e'(rr_en);

    rr_pick_n #(
        .N     (CHANNELS),
        .IDX_W (SEL_W)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // Fixed-mode grant; a sel beyond the last channel matches nothing.
    always_comb begin
        fixed_grant = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                fixed_grant = in_valid[i];
            end
        end
    end

    // Mode mux and handshake: the output stage can take a beat when empty or draining.
    always_comb begin
        candidate = sel;
        grant     = fixed_grant;
        if (mode == MODE_RR) begin
            candidate = rr_idx;
            grant     = rr_found;
        end
        load_en = ~out_valid | out_ready;
        xfer    = rst & load_en & grant;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = xfer & (candidate == SEL_W'(i));
        end
    end

    // Pick the candidate channel's data slice.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (candidate == SEL_W'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer; pointer only moves on RR transfers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SEL_W'(CHANNELS - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_chan  <= candidate;
            if (mode == MODE_RR) begin
                ptr <= candidate;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
